// File: rtl/mem_responder.sv
// Byte-addressed, big-endian memory responder with an MFA/MFC handshake.
// One access at a time, a fixed number of wait states, and an alignment check.
module mem_responder #(
  parameter int unsigned DEPTH = 256,
  parameter int unsigned WAIT  = 2
) (
  input  logic        clk_i,
  input  logic        reset_n_i,
  input  logic        mfa_i,
  input  logic        mop_sel_i,
  input  logic [1:0]  size_i,
  input  logic        se_i,
  input  logic [31:0] mar_i,
  input  logic [31:0] mdr_in_i,
  output logic [31:0] data_out_o,
  output logic        mfc_o,
  output logic        align_err_o
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = 4;
  localparam int unsigned LANES = 4;
  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [AW-1:0]   addr_q, addr_d;
  logic [31:0]     wdata_q, wdata_d;
  logic            rd_q, rd_d;
  logic [1:0]      size_q, size_d;
  logic            se_q, se_d;
  logic            mfc_q, mfc_d;
  logic            align_q, align_d;
  logic [31:0]     dout_q, dout_d;

  logic [7:0]      mem_q [DEPTH];

  logic [7:0]      rb_c [LANES];
  logic [7:0]      wr_byte_c [LANES];
  logic [LANES-1:0] wr_lane_c;
  logic [LANES-1:0] wr_en_c;
  logic [31:0]     rd_data_c;
  logic            misalign_c;
  logic            unused_mar_c;

  // Address bits above the array size are don't-care (address wraps).
  assign unused_mar_c = ^mar_i[31:AW];

  // Bytes of the latched unit, most significant first.
  always_comb begin
    for (int k = 0; k < LANES; k++) begin
      rb_c[k] = mem_q[addr_q + AW'(k)];
    end
  end

  always_comb begin
    rd_data_c = {rb_c[0], rb_c[1], rb_c[2], rb_c[3]};
    case (size_q)
      SZ_BYTE: rd_data_c = {{24{se_q & rb_c[0][7]}}, rb_c[0]};
      SZ_HALF: rd_data_c = {{16{se_q & rb_c[0][7]}}, rb_c[0], rb_c[1]};
      default: rd_data_c = {rb_c[0], rb_c[1], rb_c[2], rb_c[3]};
    endcase
  end

  assign misalign_c = ((size_q == SZ_HALF) && addr_q[0]) ||
                      (size_q[1] && (addr_q[1:0] != 2'b00));

  // Right-justified write data mapped onto big-endian byte lanes.
  always_comb begin
    wr_lane_c = '0;
    for (int k = 0; k < LANES; k++) begin
      wr_byte_c[k] = 8'h00;
    end
    case (size_q)
      SZ_BYTE: begin
        wr_lane_c    = 4'b0001;
        wr_byte_c[0] = wdata_q[7:0];
      end
      SZ_HALF: begin
        wr_lane_c    = 4'b0011;
        wr_byte_c[0] = wdata_q[15:8];
        wr_byte_c[1] = wdata_q[7:0];
      end
      default: begin
        wr_lane_c    = 4'b1111;
        wr_byte_c[0] = wdata_q[31:24];
        wr_byte_c[1] = wdata_q[23:16];
        wr_byte_c[2] = wdata_q[15:8];
        wr_byte_c[3] = wdata_q[7:0];
      end
    endcase
  end

  // Next-state and output logic.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rd_d    = rd_q;
    size_d  = size_q;
    se_d    = se_q;
    mfc_d   = mfc_q;
    align_d = align_q;
    dout_d  = dout_q;
    wr_en_c = '0;

    case (state_q)
      IDLE: begin
        if (mfa_i) begin
          addr_d  = mar_i[AW-1:0];
          wdata_d = mdr_in_i;
          rd_d    = mop_sel_i;
          size_d  = size_i;
          se_d    = se_i;
          cnt_d   = CW'(WAIT);
          state_d = BUSY;
        end
      end
      BUSY: begin
        if (!mfa_i) begin
          cnt_d   = '0;
          state_d = IDLE;
        end else if (cnt_q == '0) begin
          mfc_d   = 1'b1;
          state_d = DONE;
          if (misalign_c) begin
            align_d = 1'b1;
          end else if (rd_q) begin
            dout_d = rd_data_c;
          end else begin
            wr_en_c = wr_lane_c;
          end
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      DONE: begin
        if (!mfa_i) begin
          mfc_d   = 1'b0;
          align_d = 1'b0;
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      rd_q    <= 1'b0;
      size_q  <= 2'b00;
      se_q    <= 1'b0;
      mfc_q   <= 1'b0;
      align_q <= 1'b0;
      dout_q  <= 32'h0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rd_q    <= rd_d;
      size_q  <= size_d;
      se_q    <= se_d;
      mfc_q   <= mfc_d;
      align_q <= align_d;
      dout_q  <= dout_d;
    end
  end

  // Storage keeps its contents across reset; writes only fire from BUSY.
  always_ff @(posedge clk_i) begin
    for (int k = 0; k < LANES; k++) begin
      if (wr_en_c[k]) begin
        mem_q[addr_q + AW'(k)] <= wr_byte_c[k];
      end
    end
  end

  assign data_out_o  = dout_q;
  assign mfc_o       = mfc_q;
  assign align_err_o = align_q;

endmodule

// File: tb/tb_mem_responder.sv
// Directed bench for mem_responder: handshake latency, big-endian data paths,
// alignment errors, address wrap, abort and reset behaviour.
module tb_mem_responder;

  localparam int WAIT_C = 2;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        mfa = 1'b0;
  logic        mop_sel = 1'b0;
  logic [1:0]  size = 2'b00;
  logic        se = 1'b0;
  logic [31:0] mar = 32'h0;
  logic [31:0] mdr = 32'h0;
  logic [31:0] data_out;
  logic        mfc;
  logic        align_err;

  int n_cmp = 0;
  int n_bad = 0;

  mem_responder #(.DEPTH(256), .WAIT(WAIT_C)) dut (
    .clk_i      (clk),
    .reset_n_i  (reset_n),
    .mfa_i      (mfa),
    .mop_sel_i  (mop_sel),
    .size_i     (size),
    .se_i       (se),
    .mar_i      (mar),
    .mdr_in_i   (mdr),
    .data_out_o (data_out),
    .mfc_o      (mfc),
    .align_err_o(align_err)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] mem_word(input int a);
    return {dut.mem_q[a], dut.mem_q[a+1], dut.mem_q[a+2], dut.mem_q[a+3]};
  endfunction

  // Present a request, let it be captured, then scramble the inputs.
  task automatic issue(input logic rd, input logic [1:0] sz, input logic s,
                       input logic [31:0] a, input logic [31:0] d);
    mop_sel = rd; size = sz; se = s; mar = a; mdr = d; mfa = 1'b1;
    @(posedge clk); #1;
    mop_sel = ~rd; size = ~sz; se = ~s; mar = ~a; mdr = ~d;
  endtask

  task automatic txn(input string tag, input logic rd, input logic [1:0] sz, input logic s,
                     input logic [31:0] a, input logic [31:0] d, input logic exp_align);
    int n;
    issue(rd, sz, s, a, d);
    n = 0;
    while (mfc !== 1'b1 && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    check_eq({tag, " latency"}, 32'(n), 32'(WAIT_C + 1));
    check_eq({tag, " align"}, 32'(align_err), 32'(exp_align));
  endtask

  task automatic finish_req(input string tag);
    mfa = 1'b0;
    @(posedge clk); #1;
    check_eq({tag, " mfc_clr"}, 32'(mfc), 32'h0);
    check_eq({tag, " align_clr"}, 32'(align_err), 32'h0);
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    logic seen;
    #12;
    check_eq("rst mfc", 32'(mfc), 32'h0);
    check_eq("rst align", 32'(align_err), 32'h0);
    check_eq("rst dout", data_out, 32'h0);
    @(posedge clk); #1;
    reset_n = 1'b1;
    @(posedge clk); #1;

    txn("w_word10", 1'b0, 2'b10, 1'b0, 32'h10, 32'hA2044012, 1'b0);
    check_eq("w_word10 dout", data_out, 32'h0);
    finish_req("w_word10");
    check_eq("mem10", 32'(dut.mem_q[16]), 32'hA2);
    check_eq("mem11", 32'(dut.mem_q[17]), 32'h04);
    check_eq("mem12", 32'(dut.mem_q[18]), 32'h40);
    check_eq("mem13", 32'(dut.mem_q[19]), 32'h12);
    txn("r_word10", 1'b1, 2'b10, 1'b0, 32'h10, 32'h0, 1'b0);
    check_eq("r_word10 dout", data_out, 32'hA2044012);
    finish_req("r_word10");

    dut.mem_q[32] = 8'h9C; dut.mem_q[33] = 8'h35;
    dut.mem_q[34] = 8'h77; dut.mem_q[35] = 8'h88;
    txn("r_byte_se", 1'b1, 2'b00, 1'b1, 32'h20, 32'h0, 1'b0);
    check_eq("r_byte_se dout", data_out, 32'hFFFFFF9C);
    finish_req("r_byte_se");
    txn("r_byte_ze", 1'b1, 2'b00, 1'b0, 32'h20, 32'h0, 1'b0);
    check_eq("r_byte_ze dout", data_out, 32'h0000009C);
    finish_req("r_byte_ze");
    txn("r_half_se", 1'b1, 2'b01, 1'b1, 32'h20, 32'h0, 1'b0);
    check_eq("r_half_se dout", data_out, 32'hFFFF9C35);
    finish_req("r_half_se");

    txn("r_half_mis", 1'b1, 2'b01, 1'b0, 32'h21, 32'h0, 1'b1);
    check_eq("r_half_mis dout", data_out, 32'hFFFF9C35);
    finish_req("r_half_mis");
    txn("w_word_mis", 1'b0, 2'b10, 1'b0, 32'h22, 32'h11223344, 1'b1);
    finish_req("w_word_mis");
    check_eq("w_word_mis mem", mem_word(32), 32'h9C357788);

    dut.mem_q[4] = 8'h00; dut.mem_q[5] = 8'h00; dut.mem_q[6] = 8'h00;
    txn("w_byte_wrap", 1'b0, 2'b00, 1'b0, 32'h0000_0105, 32'h0000005A, 1'b0);
    finish_req("w_byte_wrap");
    check_eq("wrap mem05", 32'(dut.mem_q[5]), 32'h5A);
    check_eq("wrap mem04_06", {dut.mem_q[4], dut.mem_q[6]}, 32'h0);

    dut.mem_q[48] = 8'h00; dut.mem_q[49] = 8'h00; dut.mem_q[50] = 8'h00;
    txn("w_half30", 1'b0, 2'b01, 1'b0, 32'h30, 32'h1234BEEF, 1'b0);
    finish_req("w_half30");
    check_eq("half30 mem", {dut.mem_q[48], dut.mem_q[49], dut.mem_q[50]}, 32'h00BEEF00);
    txn("r_half30", 1'b1, 2'b01, 1'b1, 32'h30, 32'h0, 1'b0);
    check_eq("r_half30 dout", data_out, 32'hFFFFBEEF);
    finish_req("r_half30");

    dut.mem_q[64] = 8'h11; dut.mem_q[65] = 8'h22;
    dut.mem_q[66] = 8'h33; dut.mem_q[67] = 8'h44;
    issue(1'b0, 2'b10, 1'b0, 32'h40, 32'hDEADBEEF);
    @(posedge clk); #1;
    mfa = 1'b0;
    seen = 1'b0;
    repeat (6) begin
      @(posedge clk); #1;
      seen = seen | mfc;
    end
    check_eq("abort mfc", 32'(seen), 32'h0);
    check_eq("abort mem", mem_word(64), 32'h11223344);
    txn("w_after_abort", 1'b0, 2'b10, 1'b0, 32'h40, 32'hCAFEF00D, 1'b0);
    finish_req("w_after_abort");
    check_eq("after_abort mem", mem_word(64), 32'hCAFEF00D);

    dut.mem_q[80] = 8'hA1; dut.mem_q[81] = 8'hA2;
    dut.mem_q[82] = 8'hA3; dut.mem_q[83] = 8'hA4;
    issue(1'b0, 2'b10, 1'b0, 32'h50, 32'h12345678);
    @(posedge clk); #3;
    reset_n = 1'b0;
    #1;
    check_eq("rst_busy mfc", 32'(mfc), 32'h0);
    check_eq("rst_busy dout", data_out, 32'h0);
    @(posedge clk); #1;
    mfa = 1'b0;
    @(posedge clk); #1;
    reset_n = 1'b1;
    @(posedge clk); #1;
    check_eq("rst_busy mem", mem_word(80), 32'hA1A2A3A4);

    txn("hold", 1'b1, 2'b10, 1'b0, 32'h10, 32'h0, 1'b0);
    check_eq("hold dout", data_out, 32'hA2044012);
    repeat (5) begin
      @(posedge clk); #1;
      check_eq("hold mfc", 32'(mfc), 32'h1);
      check_eq("hold dout_stable", data_out, 32'hA2044012);
    end
    finish_req("hold");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/mem_responder.md
MEM_RESPONDER -- requirements
Module: mem_responder

Interface
REQ-001 Parameter DEPTH, default 256, memory size in bytes (power of two).
REQ-002 Parameter WAIT, default 2, wait-state cycles between request capture and completion (0..15).
REQ-003 Clk  input  1  single clock; all state changes on rising edge.
REQ-004 Reset  input  1  asynchronous, active-low reset.
REQ-005 MFA  input  1  memory function activate; initiator holds high until MFC seen.
REQ-006 MOP_SEL  input  1  operation: 1 = read, 0 = write.
REQ-007 SIZE  input  2  00 byte, 01 halfword, 10 word, 11 reserved (treated as word).
REQ-008 SE  input  1  sign-extend read data for byte/halfword.
REQ-009 MAR  input  32  byte address.
REQ-010 MDR_IN  input  32  write data, right-justified.
REQ-011 DATA_OUT  output  32  read data, right-justified.
REQ-012 MFC  output  1  memory function complete.
REQ-013 ALIGN_ERR  output  1  misaligned-access flag, valid while MFC high.

Function
REQ-014 Storage SHALL be a DEPTH-entry byte array, big-endian: byte at MAR is most significant of the accessed unit.
REQ-015 Address SHALL wrap modulo DEPTH (upper MAR bits ignored).
REQ-016 FSM states SHALL be IDLE, BUSY, DONE.
REQ-017 IDLE: on MFA=1 at a rising edge, latch MAR, MDR_IN, MOP_SEL, SIZE, SE; load wait counter with WAIT; go BUSY.
REQ-018 BUSY: counter decrements each edge; at the edge where counter equals 0, perform access, set MFC=1, go DONE.
REQ-019 Latency: MFA sampled at edge N -> MFC high after edge N+WAIT+1; WAIT=0 gives MFC after edge N+1.
REQ-020 Inputs changing after capture SHALL not affect the access in progress.
REQ-021 Write: store SIZE low-order bytes of latched MDR_IN at the latched address, big-endian; DATA_OUT unchanged.
REQ-022 Read: DATA_OUT loaded at completion; byte/halfword zero-extended when SE=0, sign-extended when SE=1.
REQ-023 Misaligned (halfword with MAR[0]=1, word with MAR[1:0]!=0): no memory write, DATA_OUT unchanged, MFC=1 with ALIGN_ERR=1.
REQ-024 DONE: MFC and DATA_OUT held until MFA sampled low; then MFC=0, ALIGN_ERR=0, go IDLE.
REQ-025 A new request SHALL not be accepted in the same edge that leaves DONE; minimum one IDLE cycle between transactions.
REQ-026 MFA sampled low while BUSY: abort, no memory write, no MFC, return to IDLE.
REQ-027 MFC SHALL be a registered output, never combinational from MFA.

Reset
REQ-028 Reset low SHALL immediately force state IDLE, MFC=0, ALIGN_ERR=0, DATA_OUT=32'h0, counter=0.
REQ-029 Reset SHALL not clear memory contents; an in-flight write aborted by reset SHALL leave memory unchanged.
REQ-030 Memory array SHALL be hierarchically accessible for bench preload and dump.

Verification
REQ-031 WAIT=2, write word 32'hA2044012 to MAR=0x10, then read word 0x10 -> MFC after 3 edges each, DATA_OUT=32'hA2044012, bytes 0x10..0x13 = A2,04,40,12.
REQ-032 Preload byte 0x20=8'h9C; read byte SE=1 -> DATA_OUT=32'hFFFFFF9C; SE=0 -> 32'h0000009C.
REQ-033 Halfword read MAR=0x21 -> MFC=1, ALIGN_ERR=1, DATA_OUT unchanged; word write MAR=0x22 -> memory unchanged, ALIGN_ERR=1.
REQ-034 DEPTH=256, write byte 8'h5A to MAR=0x0000_0105 -> byte 0x05 = 8'h5A.
REQ-035 Start write, drop MFA one cycle after capture (WAIT=2) -> MFC never rises, target bytes unchanged; next request completes normally.
REQ-036 Assert Reset low while BUSY on a write -> MFC=0 and DATA_OUT=0 immediately, target bytes unchanged; hold MFA high through DONE for 5 cycles -> MFC stays 1, DATA_OUT stable.
